// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8-N-1 asynchronous serial receiver.
//
// Deserialises a UART line (idle high, LSB first) into bytes. Each completed
// frame yields exactly one single-cycle strobe: o_Rx_DV for a good stop bit,
// o_Rx_Frame_Err for a low stop bit. After a framing error the receiver waits
// for the line to return high, so a held-low break line is never taken as a
// stream of new frames.
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per bit period (4 or more)
//
// Ports:
//   i_Clock        sole clock, rising edge
//   i_Reset        synchronous, active-high reset
//   i_Rx_Serial    asynchronous serial input, idle high
//   o_Rx_DV        one-cycle strobe, o_Rx_Byte valid in the same cycle
//   o_Rx_Byte      last good byte received; held between frames
//   o_Rx_Active    high while a frame is in progress (START, DATA, STOP)
//   o_Rx_Frame_Err one-cycle strobe when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Rx_Frame_Err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   // Start-bit check lands H cycles into the start bit, i.e. near its middle;
   // every later sample is a whole bit period further on, so all data and
   // stop samples sit near mid-bit as well.
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_START      = 3'd1;
   localparam logic [2:0] S_DATA       = 3'd2;
   localparam logic [2:0] S_STOP       = 3'd3;
   localparam logic [2:0] S_CLEANUP    = 3'd4;
   localparam logic [2:0] S_BREAK_WAIT = 3'd5;

   // two-stage synchroniser; both stages reset to the idle (high) level
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          rx_s;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;

   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_dv_q, rx_dv_d;
   logic          frame_err_q, frame_err_d;
   logic          rx_active_q, rx_active_d;

   assign rx_s = sync2_q;

   always_comb begin
      sync1_d = i_Rx_Serial;
      sync2_d = sync1_q;
   end

   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_idx_d = 3'd0;
            if (!rx_s) state_d = S_START;
         end

         S_START: begin
            if (clk_cnt_q == CNT_HALF) begin
               clk_cnt_d = '0;
               // a line already back high at mid-start was only a glitch
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_STOP: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               if (rx_s) begin
                  rx_byte_d = shift_q;
                  rx_dv_d   = 1'b1;
                  state_d   = S_CLEANUP;
               end else begin
                  // the published byte is kept; only the error strobe fires
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK_WAIT;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_CLEANUP: begin
            state_d = S_IDLE;
         end

         S_BREAK_WAIT: begin
            // a low line here is the tail of a bad frame or a break, not a
            // new start bit
            if (rx_s) state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            bit_idx_d = 3'd0;
         end
      endcase

      // registered from the next state so the flag lines up with the state
      rx_active_d = (state_d == S_START) || (state_d == S_DATA) ||
                    (state_d == S_STOP);
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_byte_q   <= 8'h00;
         rx_dv_q     <= 1'b0;
         frame_err_q <= 1'b0;
         rx_active_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         frame_err_q <= frame_err_d;
         rx_active_q <= rx_active_d;
      end
   end

   assign o_Rx_DV        = rx_dv_q;
   assign o_Rx_Byte      = rx_byte_q;
   assign o_Rx_Active    = rx_active_q;
   assign o_Rx_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 10).
//
// The whole line waveform (and reset pattern) is built up front into arrays,
// directed scenarios first and randomized frames after. A reference model
// then walks the waveform using the receiver's timing rules (what the FSM
// sees at edge E is the line two edges earlier; start check H+1 edges after
// the start is seen; data/stop samples a whole bit period apart) and fills
// per-cycle expected outputs. The run loop drives the line and compares all
// outputs every cycle, plus literal checks at hand-computed cycles.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB  = 10;
   localparam int H    = (CPB - 1) / 2;
   localparam int MAXN = 20000;

   logic       i_Clock = 1'b0;
   logic       i_Reset;
   logic       i_Rx_Serial;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Active;
   logic       o_Rx_Frame_Err;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock        (i_Clock),
      .i_Reset        (i_Reset),
      .i_Rx_Serial    (i_Rx_Serial),
      .o_Rx_DV        (o_Rx_DV),
      .o_Rx_Byte      (o_Rx_Byte),
      .o_Rx_Active    (o_Rx_Active),
      .o_Rx_Frame_Err (o_Rx_Frame_Err)
   );

   always #5 i_Clock = ~i_Clock;

   // line value and reset value presented before edge n
   bit       ln  [MAXN];
   bit       rs  [MAXN];
   // expected outputs just after edge n
   bit       edv [MAXN];
   bit       efe [MAXN];
   bit       eact[MAXN];
   bit [7:0] ebyte[MAXN];
   bit       evs [MAXN];
   bit [7:0] evv [MAXN];
   int       pos;

   int total = 0;
   int bad   = 0;
   int cyc;

   int t_a5, t_gl, t_5a, t_hi, t_42, t_b2b, t_c3, t_rst, t_96;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, want);
      end
   endtask

   task automatic push(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         ln[pos] = v;
         rs[pos] = 1'b0;
         pos++;
      end
   endtask

   task automatic frame(input logic [7:0] b, input bit stopv);
      push(1'b0, CPB);
      for (int k = 0; k < 8; k++) push(b[k], CPB);
      push(stopv, CPB);
   endtask

   // value the receiver's state machine acts on at edge e
   function automatic bit rx_at(input int e);
      if (e < 2 || e >= MAXN) return 1'b1;
      if (rs[e-1] || rs[e-2]) return 1'b1;
      return ln[e-2];
   endfunction

   task automatic set_byte(input int n, input bit [7:0] v);
      evs[n] = 1'b1;
      evv[n] = v;
   endtask

   task automatic run_model();
      int e, s, se, r;
      bit [7:0] bv;
      e = 0;
      while (e < pos) begin
         if (rs[e]) begin
            set_byte(e, 8'h00);
            e++;
            continue;
         end
         if (rx_at(e)) begin
            e++;
            continue;
         end
         s  = e + 1 + H;
         se = s + 9 * CPB;
         if (se + 2 >= pos) break;
         r = -1;
         for (int k = e + 1; k <= se; k++)
            if (rs[k]) begin r = k; break; end
         if (r >= 0 && (r <= s || !rx_at(s))) begin
            for (int k = e; k < r; k++) eact[k] = 1'b1;
            e = r;
            continue;
         end
         if (rx_at(s)) begin
            for (int k = e; k < s; k++) eact[k] = 1'b1;
            e = s + 1;
            continue;
         end
         for (int k = 0; k < 8; k++) bv[k] = rx_at(s + (k + 1) * CPB);
         for (int k = e; k < se; k++) eact[k] = 1'b1;
         if (rx_at(se)) begin
            edv[se] = 1'b1;
            set_byte(se, bv);
            e = rs[se+1] ? se + 1 : se + 2;
         end else begin
            efe[se] = 1'b1;
            e = se + 1;
            while (e < pos && !rs[e] && !rx_at(e)) e++;
            if (e < pos && !rs[e]) e++;
         end
      end
      begin
         bit [7:0] cur;
         cur = 8'h00;
         for (int n = 0; n < pos; n++) begin
            if (evs[n]) cur = evv[n];
            ebyte[n] = cur;
         end
      end
   endtask

   initial begin
      int gl_act, gl_strb, brk_strb, rst_strb, nfr;
      logic [7:0] c3;
      for (int n = 0; n < MAXN; n++) begin
         ln[n] = 1'b1; rs[n] = 1'b0; edv[n] = 1'b0; efe[n] = 1'b0;
         eact[n] = 1'b0; ebyte[n] = 8'h00; evs[n] = 1'b0; evv[n] = 8'h00;
      end
      pos = 0;

      // reset, then directed scenarios
      push(1'b1, 4);
      for (int n = 0; n < 4; n++) rs[n] = 1'b1;
      push(1'b1, 20);
      t_a5 = pos; frame(8'hA5, 1'b1); push(1'b1, 15);
      t_gl = pos; push(1'b0, 3); push(1'b1, 40);
      frame(8'h3C, 1'b1); push(1'b1, 5);
      frame(8'h81, 1'b1); push(1'b1, 5);
      t_5a = pos; frame(8'h5A, 1'b0); push(1'b0, 30 * CPB);
      t_hi = pos; push(1'b1, 20);
      t_42 = pos; frame(8'h42, 1'b1); push(1'b1, 10);
      t_b2b = pos; frame(8'h00, 1'b1); frame(8'hFF, 1'b1); frame(8'h55, 1'b1);
      push(1'b1, 20);
      // 0xC3 aborted by a one-cycle reset in the middle of data bit 4
      c3 = 8'hC3;
      t_c3 = pos; push(1'b0, CPB);
      for (int k = 0; k < 4; k++) push(c3[k], CPB);
      push(c3[4], 5);
      t_rst = pos; push(1'b1, 40); rs[t_rst] = 1'b1;
      t_96 = pos; frame(8'h96, 1'b1); push(1'b1, 20);

      // randomized traffic: bad stops, short/long glitches, stray resets
      nfr = 0;
      while (pos < MAXN - 800 && nfr < 60) begin
         int st;
         st = pos;
         if ($urandom_range(0, 5) == 0) begin
            push(1'b0, $urandom_range(1, 8));
            push(1'b1, 20);
         end
         st = pos;
         if ($urandom_range(0, 7) != 0) begin
            frame(8'($urandom_range(0, 255)), 1'b1);
         end else begin
            frame(8'($urandom_range(0, 255)), 1'b0);
            push(1'b0, $urandom_range(0, 3 * CPB));
         end
         if ($urandom_range(0, 9) == 0) rs[st + $urandom_range(0, 10 * CPB - 1)] = 1'b1;
         push(1'b1, $urandom_range(0, 2 * CPB));
         nfr++;
      end
      push(1'b1, 200);

      run_model();

      gl_act = 0; gl_strb = 0; brk_strb = 0; rst_strb = 0;
      i_Reset     = rs[0];
      i_Rx_Serial = ln[0];
      for (int n = 0; n < pos; n++) begin
         @(posedge i_Clock);
         #1;
         cyc = n;
         chk("dv",       32'(o_Rx_DV),        32'(edv[n]));
         chk("frame_err", 32'(o_Rx_Frame_Err), 32'(efe[n]));
         chk("active",   32'(o_Rx_Active),    32'(eact[n]));
         chk("byte",     32'(o_Rx_Byte),      32'(ebyte[n]));

         // literal expectations pinning the model
         if (n == 3) begin
            chk("rst_dv", 32'(o_Rx_DV), 0);
            chk("rst_fe", 32'(o_Rx_Frame_Err), 0);
            chk("rst_act", 32'(o_Rx_Active), 0);
            chk("rst_byte", 32'(o_Rx_Byte), 0);
         end
         if (n == t_a5 + 96) begin
            chk("a5_pre_dv", 32'(o_Rx_DV), 0);
            chk("a5_pre_act", 32'(o_Rx_Active), 1);
         end
         if (n == t_a5 + 97) begin
            chk("a5_dv", 32'(o_Rx_DV), 1);
            chk("a5_byte", 32'(o_Rx_Byte), 32'hA5);
            chk("a5_fe", 32'(o_Rx_Frame_Err), 0);
            chk("a5_act", 32'(o_Rx_Active), 0);
         end
         if (n == t_a5 + 98) chk("a5_dv_once", 32'(o_Rx_DV), 0);

         if (n >= t_gl && n < t_gl + 40) begin
            gl_act  += int'(o_Rx_Active);
            gl_strb += int'(o_Rx_DV) + int'(o_Rx_Frame_Err);
         end
         if (n == t_gl + 40) begin
            chk("glitch_act_1to6", 32'(gl_act >= 1 && gl_act <= 6), 1);
            chk("glitch_strobes", 32'(gl_strb), 0);
            chk("glitch_byte", 32'(o_Rx_Byte), 32'hA5);
         end

         if (n == t_5a + 97) begin
            chk("5a_fe", 32'(o_Rx_Frame_Err), 1);
            chk("5a_dv", 32'(o_Rx_DV), 0);
            chk("5a_byte_kept", 32'(o_Rx_Byte), 32'h81);
         end
         if (n > t_5a + 97 && n < t_hi + 5)
            brk_strb += int'(o_Rx_DV) + int'(o_Rx_Frame_Err);
         if (n == t_hi + 5) chk("break_strobes", 32'(brk_strb), 0);
         if (n == t_42 + 97) begin
            chk("42_dv", 32'(o_Rx_DV), 1);
            chk("42_byte", 32'(o_Rx_Byte), 32'h42);
         end

         for (int k = 0; k < 3; k++) begin
            if (n == t_b2b + 97 + k * 10 * CPB) begin
               chk("b2b_dv", 32'(o_Rx_DV), 1);
               chk("b2b_byte", 32'(o_Rx_Byte), (k == 0) ? 32'h00 : (k == 1) ? 32'hFF : 32'h55);
            end
         end

         if (n >= t_c3 && n < t_96)
            rst_strb += int'(o_Rx_DV) + int'(o_Rx_Frame_Err);
         if (n == t_rst) begin
            chk("midrst_dv", 32'(o_Rx_DV), 0);
            chk("midrst_fe", 32'(o_Rx_Frame_Err), 0);
            chk("midrst_act", 32'(o_Rx_Active), 0);
            chk("midrst_byte", 32'(o_Rx_Byte), 0);
         end
         if (n == t_96) chk("midrst_strobes", 32'(rst_strb), 0);
         if (n == t_96 + 97) begin
            chk("96_dv", 32'(o_Rx_DV), 1);
            chk("96_byte", 32'(o_Rx_Byte), 32'h96);
         end

         if (o_Rx_DV === 1'b1 && o_Rx_Frame_Err === 1'b1)
            chk("dv_fe_exclusive", 32'(o_Rx_DV & o_Rx_Frame_Err), 0);

         i_Reset     = (n + 1 < MAXN) ? rs[n+1] : 1'b0;
         i_Rx_Serial = (n + 1 < MAXN) ? ln[n+1] : 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
